// File: rtl/wavetable_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_pkg
// Purpose  : Shared types and defaults for the wavetable voice reader:
//            FSM state encoding, table geometry defaults and the phase wrap
//            constant (TABLE_LEN << FRAC_W).
// Revision : 1.0 - initial release
// ============================================================================
package wavetable_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    CAP1 = 3'd3,
    CALC = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_TABLE_LEN = 8094;
  localparam int DEF_FRAC_W    = 16;
  localparam int DEF_GAIN_W    = 8;

  // Amount subtracted from the widened phase sum when the index passes the
  // end of the table.
  function automatic logic [63:0] wrap_value(input int table_len, input int frac_w);
    return 64'(table_len) << frac_w;
  endfunction

  localparam logic [DEF_ADDR_W+DEF_FRAC_W:0] WRAP_CONST =
    (DEF_ADDR_W+DEF_FRAC_W+1)'(wrap_value(DEF_TABLE_LEN, DEF_FRAC_W));

endpackage
`default_nettype wire

// File: rtl/wavetable_lerp.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_lerp
// Purpose  : Combinational linear interpolation between two table samples
//            followed by an unsigned gain of value/256.
// Ports    : s0, s1 - adjacent signed table samples
//            fr     - 8-bit interpolation fraction (0 = s0)
//            gain   - unsigned gain, scale = gain/256
//            y      - signed scaled, interpolated sample
// Revision : 1.0 - initial release
// ============================================================================
module wavetable_lerp #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8
) (
  input  logic signed [DATA_W-1:0] s0,
  input  logic signed [DATA_W-1:0] s1,
  input  logic        [7:0]        fr,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [DATA_W-1:0] y
);

  localparam int PW = DATA_W + 10;          // d (DATA_W+1) x {0,fr} (9)
  localparam int GW = DATA_W + GAIN_W + 1;  // lerp x {0,gain}

  logic signed [DATA_W:0]   d;
  logic signed [PW-1:0]     d_ext;
  logic signed [PW-1:0]     fr_ext;
  logic signed [PW-1:0]     p;
  logic signed [PW-1:0]     p_shift;
  logic signed [PW-1:0]     s0_ext;
  logic signed [PW-1:0]     lerp_full;
  logic signed [DATA_W-1:0] lerp;
  logic signed [GW-1:0]     lerp_g;
  logic signed [GW-1:0]     gain_g;
  logic signed [GW-1:0]     prod;
  logic signed [GW-1:0]     prod_sh;
  logic                     unused_bits;

  assign d         = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
  assign d_ext     = {{(PW-DATA_W-1){d[DATA_W]}}, d};
  assign fr_ext    = {{(PW-8){1'b0}}, fr};
  assign p         = d_ext * fr_ext;
  assign p_shift   = p >>> 8;
  assign s0_ext    = {{(PW-DATA_W){s0[DATA_W-1]}}, s0};
  assign lerp_full = s0_ext + p_shift;
  // The interpolant always lies between s0 and s1, so the low DATA_W bits
  // carry the full value.
  assign lerp      = lerp_full[DATA_W-1:0];

  assign lerp_g    = {{(GW-DATA_W){lerp[DATA_W-1]}}, lerp};
  assign gain_g    = {{(GW-GAIN_W){1'b0}}, gain};
  assign prod      = lerp_g * gain_g;
  // Arithmetic shift floors toward minus infinity; gain < 256 keeps it in range.
  assign prod_sh   = prod >>> 8;
  assign y         = prod_sh[DATA_W-1:0];

  assign unused_bits = ^{lerp_full[PW-1:DATA_W], prod_sh[GW-1:DATA_W]};

endmodule
`default_nettype wire

// File: rtl/wavetable_voice_reader.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_voice_reader
// Purpose  : Wavetable playback voice. On each accepted sample tick it steps
//            a 13.16 phase accumulator, reads two adjacent words from the
//            sample RAM, interpolates, applies gain and offers the result on
//            a valid/ready output.
// Ports    : clk, reset_n           - clock, async active-low reset
//            sample_tick, enable    - sample strobe, voice enable
//            phase_inc, gain        - tuning word (13.16), gain (value/256)
//            mem_address/chipselect/readdata - RAM read master (1-cycle data)
//            sample_out/valid/ready - output stream
//            busy, overrun          - status: not idle, tick dropped
// Revision : 1.0 - initial release
// ============================================================================
module wavetable_voice_reader
  import wavetable_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TABLE_LEN = DEF_TABLE_LEN,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int GAIN_W    = DEF_GAIN_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic                       enable,
  input  logic [ADDR_W+FRAC_W-1:0]   phase_inc,
  input  logic [GAIN_W-1:0]          gain,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_chipselect,
  input  logic [DATA_W-1:0]          mem_readdata,
  output logic signed [DATA_W-1:0]   sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       busy,
  output logic                       overrun
);

  localparam int                PH_W     = ADDR_W + FRAC_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TABLE_LEN - 1);
  localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W+1)'(TABLE_LEN);
  localparam logic [PH_W:0]     WRAP     = (PH_W+1)'(wrap_value(TABLE_LEN, FRAC_W));

  state_t                   state, state_next;
  logic                     accept;
  logic                     drop;
  logic [PH_W-1:0]          phase;
  logic [ADDR_W-1:0]        idx0;
  logic [ADDR_W-1:0]        idx1;
  logic [7:0]               fr;
  logic signed [DATA_W-1:0] s0, s1;
  logic signed [DATA_W-1:0] lerp_y;
  logic [ADDR_W-1:0]        inc_idx;
  logic [ADDR_W-1:0]        inc_idx_clamped;
  logic [PH_W-1:0]          inc_clamped;
  logic [PH_W:0]            sum;
  logic [PH_W:0]            sum_wrapped;
  logic                     unused_wrap_msb;

  // Tuning word integer part saturates at the last table index.
  assign inc_idx         = phase_inc[PH_W-1:FRAC_W];
  assign inc_idx_clamped = (inc_idx > LAST_IDX) ? LAST_IDX : inc_idx;
  assign inc_clamped     = {inc_idx_clamped, phase_inc[FRAC_W-1:0]};

  // Both operands are below TABLE_LEN, so a single subtraction wraps.
  assign sum             = {1'b0, phase} + {1'b0, inc_clamped};
  assign sum_wrapped     = (sum[PH_W:FRAC_W] >= LEN_EXT) ? (sum - WRAP) : sum;
  assign unused_wrap_msb = sum_wrapped[PH_W];

  assign idx1 = (idx0 == LAST_IDX) ? '0 : idx0 + 1'b1;

  assign busy = (state != IDLE);
  assign drop = enable && sample_tick && (state != IDLE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && sample_tick) begin
          accept     = 1'b1;
          state_next = RD0;
        end
      end
      RD0:     state_next = RD1;
      RD1:     state_next = CAP1;
      CAP1:    state_next = CALC;
      CALC:    state_next = OUT;
      OUT:     if (sample_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Address and chipselect are registered one step ahead so they are valid
  // throughout RD0 and RD1; read data arrives in the following state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase          <= '0;
      idx0           <= '0;
      fr             <= '0;
      s0             <= '0;
      s1             <= '0;
      sample_out     <= '0;
      sample_valid   <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= drop;

      if (!enable)     phase <= '0;
      else if (accept) phase <= sum_wrapped[PH_W-1:0];

      case (state)
        IDLE: begin
          if (accept) begin
            idx0           <= phase[PH_W-1:FRAC_W];
            fr             <= phase[FRAC_W-1 -: 8];
            mem_address    <= phase[PH_W-1:FRAC_W];
            mem_chipselect <= 1'b1;
          end
        end
        RD0: mem_address <= idx1;
        RD1: begin
          s0             <= mem_readdata;
          mem_chipselect <= 1'b0;
        end
        CAP1: s1 <= mem_readdata;
        CALC: begin
          sample_out   <= lerp_y;
          sample_valid <= 1'b1;
        end
        OUT: if (sample_ready) sample_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  wavetable_lerp #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_lerp (
    .s0   (s0),
    .s1   (s1),
    .fr   (fr),
    .gain (gain),
    .y    (lerp_y)
  );

endmodule
`default_nettype wire

// File: doc/wavetable_voice_reader.md
# wavetable_voice_reader

Wavetable playback engine that drives the single-port 16-bit bass sample RAM (8094 words, 13-bit address) as its read master and turns stored samples into a pitched audio stream. On each sample tick it:
- advances a fractional phase accumulator;
- fetches two adjacent table words;
- linearly interpolates between them and applies a gain;
- hands the result downstream to the audio output path over a valid/ready handshake.

## Interface

Parameters:
- ADDR_W, 13, RAM address width
- DATA_W, 16, sample width, two's complement
- TABLE_LEN, 8094, words in table; index wraps at this value
- FRAC_W, 16, fractional phase bits
- GAIN_W, 8, unsigned gain width

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle strobe per audio sample period
- enable  in  1  voice on; low clears phase and ignores ticks
- phase_inc  in  ADDR_W+FRAC_W  unsigned tuning word, 13.16 fixed point, sampled at tick acceptance
- gain  in  GAIN_W  unsigned output scale, value/256
- mem_address  out  ADDR_W  RAM address
- mem_chipselect  out  1  high while an address is being read
- mem_readdata  in  DATA_W  RAM data, valid the cycle after address is presented
- sample_out  out  DATA_W  signed output sample
- sample_valid  out  1  sample_out valid
- sample_ready  in  1  downstream accepts
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  one-cycle pulse when a tick is dropped

## Operation

- **Phase.** `phase` register, ADDR_W+FRAC_W bits, integer part idx, fractional part frac.
- **Tuning word clamp.** If the integer part of phase_inc is ≥ TABLE_LEN, clamp it to TABLE_LEN-1 and keep its fraction.
- **Tick acceptance** (IDLE, enable=1, sample_tick=1):
  - latch idx0 = idx, fr = frac[FRAC_W-1 -: 8];
  - sum = phase + inc, computed at ADDR_W+FRAC_W+1 bits;
  - if sum integer part ≥ TABLE_LEN, subtract TABLE_LEN<<FRAC_W;
  - write the result to phase.
- **Second address.** idx1 = idx0+1, or 0 when idx0 = TABLE_LEN-1.
- **FSM:**
  - IDLE → RD0 on accepted tick.
  - RD0: mem_address=idx0, chipselect=1 → RD1.
  - RD1: capture s0=mem_readdata; mem_address=idx1, chipselect=1 → CAP1.
  - CAP1: capture s1 → CALC.
  - CALC: register the result → OUT.
  - OUT: sample_valid=1; when sample_ready=1 → IDLE.
- **Interpolation:**
  - d = s1 - s0 (17-bit signed);
  - p = d × {0,fr} (26-bit signed);
  - lerp = s0 + (p >>> 8).
  - lerp always lies between s0 and s1, so no overflow.
- **Gain:**
  - y = (lerp × {0,gain}) >>> 8;
  - the arithmetic shift floors toward −∞;
  - y fits DATA_W; no saturation needed.
- **Overrun.** A tick arriving in any state other than IDLE is dropped, overrun pulses for one cycle, and phase is unchanged.
- **enable low:**
  - phase cleared to 0;
  - ticks ignored, with no overrun;
  - an in-flight sample still completes and is delivered.
- **Address hold.** mem_address holds its last value when chipselect is low.

## Timing

- **Reset.** Asserting reset_n low asynchronously clears:
  - state=IDLE, phase=0, sample_out=0;
  - sample_valid=0, mem_address=0, mem_chipselect=0;
  - busy=0, overrun=0.
- **Latency.** Tick accepted in cycle T gives RD0 in T+1, RD1 in T+2, CAP1 in T+3, CALC in T+4. sample_valid rises in T+5.
- **Handshake.**
  - While valid=1 and ready=0, sample_out and sample_valid hold stable.
  - Valid drops the cycle after the handshake.
  - The earliest next accepted tick is the cycle after returning to IDLE.
- **Reset mid-operation.** Abandons the sample immediately; no partial output is delivered.
- **Same-cycle events.** A tick in the same cycle as the OUT handshake counts as an overrun.

## Structure

- **Package `wavetable_pkg`:**
  - state enum (IDLE, RD0, RD1, CAP1, CALC, OUT);
  - TABLE_LEN, FRAC_W, GAIN_W defaults;
  - the wrap constant TABLE_LEN<<FRAC_W.
- **Sub-module `wavetable_lerp`:** combinational interpolation and gain (s0, s1, fr, gain → y). The top-level module registers its output in CALC.

## Test plan

1. **Unity step.** Ramp table s[i]=i, phase_inc=0x10000, gain=255, ready=1.
   - Successive ticks → 0,0,1,2,... scaled by 255/256 (floor).
   - sample_valid exactly 5 cycles after each tick.
2. **Wrap.**
   - Start phase at idx 8093, inc=1.0 → reads address 8093 then 0; the next sample comes from idx 0.
   - inc = 8094.0 → clamps to 8093.0.
3. **Interpolation.**
   - inc=0x8000, gain=0 → output 0.
   - With gain=256 emulated via a ramp check, s0=100, s1=200 → 100,150,200.
   - s0=-100, s1=100, fr=0x80 → 0.
4. **Gain floor.**
   - lerp=1000, gain=128 → 500.
   - lerp=-1, gain=128 → -1.
   - gain=0 → 0.
5. **Backpressure/overrun.** Ready low for 10 cycles.
   - Valid and data stable throughout.
   - A tick during the stall → one-cycle overrun pulse; phase unchanged; the next sample uses the un-advanced phase.
6. **Reset/enable.**
   - reset_n low during RD1 → all outputs 0 the same cycle; after release, the first tick reads address 0.
   - enable low → phase cleared and ticks ignored without overrun.
